// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

    localparam int SA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full adder slice
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_core.sv
// rtl/serial_add_core.sv - LSB-first bit-serial adder with start/busy/done; SERIAL_ADD_OVF_EN adds ovf
module serial_add_core
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    sa_state_t        state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    full_adder_bit u_fa (
        .x  (a_r[0]),
        .y  (b_r[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The edge that consumes the MSB pair also closes the operation.
    assign last_bit = (count == CW'(WIDTH - 1));

    // Control FSM and serial datapath: load on accepted start, one bit per enabled edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        sum   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        a_r   <= a_r >> 1;
                        b_r   <= b_r >> 1;
                        carry <= fa_co;
                        sum   <= {fa_s, sum[WIDTH-1:1]};
                        count <= count + CW'(1);
                        if (last_bit) begin
                            cout  <= fa_co;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it; captured alongside cout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && en && last_bit) begin
            ovf <= carry ^ fa_co;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_core.sv
// tb/tb_serial_add_core.sv - scoreboard bench for serial_add_core against a+b+cin
module tb_serial_add_core;
    import serial_adder_pkg::*;

    localparam int W = SA_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         en = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        int           id;
        int           due;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   done_id = 0;
    int   next_id = 0;
    int   checks = 0;
    int   errors = 0;

    serial_add_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition, signed range test for overflow.
    function automatic exp_t model(input int av, input int bv, input int ci);
        exp_t e;
        int   tot;
        int   sa;
        int   sbv;
        int   r;
        tot    = av + bv + ci;
        sa     = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sbv    = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        r      = sa + sbv + ci;
        e.id   = 0;
        e.due  = 0;
        e.sum  = tot[W-1:0];
        e.cout = tot[W];
        e.ovf  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst && done) begin
            check("busy_in_done", busy, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("sum", sum, mon_e.sum);
                check("cout", cout, mon_e.cout);
                check("done_cycle", cyc, mon_e.due);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf", ovf, mon_e.ovf);
`endif
                done_id = mon_e.id;
            end
        end
    end

    task automatic issue(input int av, input int bv, input int ci, input int stall_at,
                         input int stall_len, output int id, output int due);
        exp_t e;
        int   e0;
        a     = av[W-1:0];
        b     = bv[W-1:0];
        cin   = ci[0];
        start = 1'b1;
        e0    = cyc + 1;
        due   = e0 + W + stall_len;
        e     = model(av, bv, ci);
        e.due = due;
        next_id++;
        e.id  = next_id;
        id    = next_id;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        repeat (stall_at) @(negedge clk);
        en = 1'b0;
        repeat (stall_len) @(negedge clk);
        en = 1'b1;
    endtask

    task automatic wait_done(input int id, input int due);
        while (cyc < due) @(negedge clk);
        #1;
        checks++;
        if (done_id < id) begin
            errors++;
            $display("FAIL completion: op %0d got last done id %0d expected >= %0d by cycle %0d",
                     id, done_id, id, due);
            while (sb.size() > 0 && sb[0].id <= id) sb.delete(0);
        end
    endtask

    task automatic run_op(input int av, input int bv, input int ci, input int stall_at,
                          input int stall_len);
        int id;
        int due;
        issue(av, bv, ci, stall_at, stall_len, id, due);
        wait_done(id, due);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected end of test");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $finish;
    end

    initial begin
        int   id1;
        int   id2;
        int   e0;
        int   due2;
        exp_t e;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        run_op(5, 6, 0, 0, 0);
        run_op(15, 1, 0, 0, 0);
        run_op(7, 8, 1, 0, 0);

        // Reset lands on the second shift edge; nothing may survive it.
        a     = 4'd1;
        b     = 4'd0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        run_op(12, 10, 1, 0, 0);

        run_op(9, 3, 1, 2, 3);
        run_op(6, 13, 0, 0, 1);

        // Start held high: ignored while shifting, accepted in DONE.
        a     = 4'd3;
        b     = 4'd4;
        cin   = 1'b0;
        start = 1'b1;
        e0    = cyc + 1;
        e     = model(3, 4, 0);
        e.due = e0 + W;
        next_id++;
        e.id  = next_id;
        id1   = next_id;
        sb.push_back(e);
        @(negedge clk);
        a   = 4'd14;
        b   = 4'd13;
        cin = 1'b1;
        while (cyc < e0 + W) @(negedge clk);
        due2  = e0 + W + 1 + W;
        e     = model(14, 13, 1);
        e.due = due2;
        next_id++;
        e.id  = next_id;
        id2   = next_id;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(id1, e0 + W);
        wait_done(id2, due2);

        run_op(7, 1, 0, 0, 0);
        run_op(15, 1, 0, 0, 0);

        for (int t = 0; t < (1 << (2 * W + 1)); t++) begin
            int sl;
            int sa_at;
            sl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            sa_at = int'($urandom_range(0, W - 1));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(t & ((1 << W) - 1), (t >> W) & ((1 << W) - 1), (t >> (2 * W)) & 1, sa_at, sl);
        end

        repeat (3) @(negedge clk);
        check("leftover_expected", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
